// File: rtl/wed_writeback_control.sv
// WED status writeback: builds a 128-byte status line and writes it
// to the line after the WED with WRITE_NA, serving PSL buffer reads.
package wed_wb_pkg;

  localparam logic [7:0] WED_ID = 8'hFE;

  typedef enum logic [12:0] {
    READ_CL_NA = 13'h0A00,
    WRITE_NA   = 13'h0D00
  } command_type;

  typedef enum logic [3:0] {
    CMD_INVALID = 4'd0,
    CMD_READ    = 4'd1,
    CMD_WRITE   = 4'd2,
    CMD_WED     = 4'd3
  } command_class;

  typedef enum logic [1:0] {
    STRUCT_INVALID = 2'd0,
    STRUCT_DATA    = 2'd1
  } array_struct_type;

  typedef enum logic [2:0] {
    STRICT = 3'b000,
    ABORT  = 3'b001,
    PAGE   = 3'b010,
    PREF   = 3'b011,
    SPEC   = 3'b111
  } trans_order_t;

  typedef enum logic [7:0] {
    DONE    = 8'h00,
    AERROR  = 8'h01,
    DERROR  = 8'h03,
    FAILED  = 8'h08,
    PAGED   = 8'h0A
  } psl_response_t;

  typedef struct packed {
    logic [7:0]       cu_id_x;
    logic [7:0]       cu_id_y;
    command_class     cmd_type;
    array_struct_type array_struct;
    logic [31:0]      real_size;
    logic [15:0]      real_size_bytes;
    logic [6:0]       address_offset;
    logic [7:0]       tag;
  } CommandTagLine;

  typedef struct packed {
    logic          valid;
    command_type   command;
    trans_order_t  abt;
    logic [63:0]   address;
    logic [11:0]   size;
    CommandTagLine cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic          valid;
    psl_response_t response;
    CommandTagLine cmd;
  } ResponseBufferLine;

  typedef struct packed {
    CommandTagLine cmd;
    logic [511:0]  data;
  } ReadWriteDataPayload;

  typedef struct packed {
    logic                valid;
    ReadWriteDataPayload payload;
  } ReadWriteDataLine;

  typedef struct packed {
    logic [63:0] address;
  } WEDPayload;

  typedef struct packed {
    logic      valid;
    WEDPayload payload;
  } WEDInterface;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

endpackage

module wed_writeback_control
  import wed_wb_pkg::*;
#(
  parameter logic [63:0] STATUS_OFFSET = 64'd128,
  parameter int          MAX_RETRIES   = 3
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  WEDInterface       wed_request_in,
  input  logic              done_in,
  input  logic [63:0]       done_status_in,
  input  BufferStatus       command_buffer_status,
  input  ResponseBufferLine wed_response_in,
  input  logic              buffer_read_valid_in,
  input  logic              buffer_read_half_in,
  output CommandBufferLine  command_out,
  output ReadWriteDataLine  wed_write_data_out,
  output logic              writeback_done_out,
  output logic              writeback_error_out
);

  typedef enum logic [2:0] {
    WB_RESET,
    WB_IDLE,
    WB_WAIT_DONE,
    WB_REQ,
    WB_WAITING_FOR_RESPONSE,
    WB_RETRY,
    WB_DONE,
    WB_ERROR
  } wb_state_t;

  localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);

  localparam CommandTagLine WB_TAG = '{
    cu_id_x:         WED_ID,
    cu_id_y:         WED_ID,
    cmd_type:        CMD_WED,
    array_struct:    STRUCT_INVALID,
    real_size:       32'd32,
    real_size_bytes: 16'd128,
    address_offset:  7'd0,
    tag:             8'd1
  };

  wb_state_t     state;
  logic          enabled;
  logic [63:0]   wed_address;
  logic [63:0]   cycles;
  logic [63:0]   status;
  logic [7:0]    retry;
  logic          done_pending;
  logic [1023:0] line;

  logic resp_match;
  logic serve_read;
  logic alfull;
  logic unused_bits;

  assign alfull      = command_buffer_status.alfull;
  assign unused_bits = ^{command_buffer_status, wed_response_in};
  assign resp_match  = wed_response_in.valid &&
                       (wed_response_in.cmd.cu_id_x == WED_ID) &&
                       (wed_response_in.cmd.tag == 8'd1);
  assign serve_read  = buffer_read_valid_in &&
                       ((state == WB_REQ) ||
                        (state == WB_WAITING_FOR_RESPONSE) ||
                        (state == WB_RETRY));

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      state               <= WB_RESET;
      enabled             <= 1'b0;
      wed_address         <= '0;
      cycles              <= '0;
      status              <= '0;
      retry               <= '0;
      done_pending        <= 1'b0;
      line                <= '0;
      command_out         <= '0;
      wed_write_data_out  <= '0;
      writeback_done_out  <= 1'b0;
      writeback_error_out <= 1'b0;
    end else begin
      enabled            <= enabled_in;
      command_out        <= '0;
      wed_write_data_out <= '0;

      if (serve_read) begin
        wed_write_data_out.valid        <= 1'b1;
        wed_write_data_out.payload.cmd  <= WB_TAG;
        wed_write_data_out.payload.data <= buffer_read_half_in ?
                                           line[1023:512] : line[511:0];
      end

      if (state == WB_REQ) begin
        command_out <= '{
          valid:   1'b1,
          command: WRITE_NA,
          abt:     STRICT,
          address: wed_address + STATUS_OFFSET,
          size:    12'h080,
          cmd:     WB_TAG
        };
      end

      writeback_done_out  <= writeback_done_out | (state == WB_DONE);
      writeback_error_out <= writeback_error_out | (state == WB_ERROR);

      unique case (state)
        WB_RESET: state <= WB_IDLE;
        WB_IDLE: begin
          if (enabled && wed_request_in.valid) begin
            state        <= WB_WAIT_DONE;
            wed_address  <= wed_request_in.payload.address;
            cycles       <= '0;
            done_pending <= 1'b0;
          end
        end
        WB_WAIT_DONE: begin
          if (cycles != '1) cycles <= cycles + 64'd1;
          if (done_in && !done_pending) begin
            done_pending <= 1'b1;
            status       <= done_status_in;
          end
          // snapshot: word0 status, word1 cycles, word2 retry
          if (done_pending && !alfull) begin
            state <= WB_REQ;
            line  <= {832'd0, 56'd0, retry, cycles, status};
          end
        end
        WB_REQ: state <= WB_WAITING_FOR_RESPONSE;
        WB_WAITING_FOR_RESPONSE: begin
          if (resp_match) begin
            if (wed_response_in.response == DONE) begin
              state <= WB_DONE;
            end else if (retry < MAX_R) begin
              state <= WB_RETRY;
              retry <= retry + 8'd1;
            end else begin
              state <= WB_ERROR;
            end
          end
        end
        WB_RETRY: begin
          if (!alfull) begin
            state         <= WB_REQ;
            line[191:128] <= {56'd0, retry};
          end
        end
        WB_DONE:  state <= WB_DONE;
        WB_ERROR: state <= WB_ERROR;
        default:  state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wed_writeback_control.sv
// Randomized bench for wed_writeback_control with a line-level
// reference model of the status writeback.
module tb_wed_writeback_control;
  import wed_wb_pkg::*;

  logic              clock = 1'b0;
  logic              rstn_in = 1'b0;
  logic              enabled_in = 1'b0;
  WEDInterface       wed_request_in;
  logic              done_in;
  logic [63:0]       done_status_in;
  BufferStatus       command_buffer_status;
  ResponseBufferLine wed_response_in;
  logic              buffer_read_valid_in;
  logic              buffer_read_half_in;
  CommandBufferLine  command_out;
  ReadWriteDataLine  wed_write_data_out;
  logic              writeback_done_out;
  logic              writeback_error_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ncmd = 0;

  wed_writeback_control dut (
    .clock(clock),
    .rstn_in(rstn_in),
    .enabled_in(enabled_in),
    .wed_request_in(wed_request_in),
    .done_in(done_in),
    .done_status_in(done_status_in),
    .command_buffer_status(command_buffer_status),
    .wed_response_in(wed_response_in),
    .buffer_read_valid_in(buffer_read_valid_in),
    .buffer_read_half_in(buffer_read_half_in),
    .command_out(command_out),
    .wed_write_data_out(wed_write_data_out),
    .writeback_done_out(writeback_done_out),
    .writeback_error_out(writeback_error_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (command_out.valid) ncmd <= ncmd + 1;

  function automatic logic [511:0] model_half(input logic [63:0] st,
      input logic [63:0] cy, input logic [63:0] rt, input logic h);
    logic [1023:0] l;
    l = 1024'(st) | (1024'(cy) << 64) | (1024'(rt) << 128);
    return h ? l[1023:512] : l[511:0];
  endfunction

  function automatic CommandTagLine exp_tag();
    CommandTagLine t;
    t = '0;
    t.cu_id_x = WED_ID;
    t.cu_id_y = WED_ID;
    t.cmd_type = CMD_WED;
    t.array_struct = STRUCT_INVALID;
    t.real_size = 32'd32;
    t.real_size_bytes = 16'd128;
    t.tag = 8'd1;
    return t;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wed_request_in = '0;
    done_in = 1'b0;
    done_status_in = '0;
    command_buffer_status = '0;
    wed_response_in = '0;
    buffer_read_valid_in = 1'b0;
    buffer_read_half_in = 1'b0;
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    idle_inputs();
    step();
    step();
    rstn_in = 1'b1;
    step();
  endtask

  task automatic start(input logic [63:0] a, output int w);
    enabled_in = 1'b1;
    step();
    step();
    wed_request_in.valid = 1'b1;
    wed_request_in.payload.address = a;
    w = cyc;
    step();
    wed_request_in = '0;
  endtask

  task automatic pulse_done(input logic [63:0] st, output int dc);
    done_in = 1'b1;
    done_status_in = st;
    dc = cyc;
    step();
    done_in = 1'b0;
    done_status_in = {$urandom, $urandom};
  endtask

  task automatic wait_cmd(input int budget, output int c, output bit ok);
    ok = 1'b0;
    c = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (command_out.valid) begin
        ok = 1'b1;
        c = cyc;
      end
    end
  endtask

  task automatic read_half(input logic h, output logic v,
      output logic [511:0] d, output logic [7:0] cu);
    buffer_read_valid_in = 1'b1;
    buffer_read_half_in = h;
    step();
    buffer_read_valid_in = 1'b0;
    v = wed_write_data_out.valid;
    d = wed_write_data_out.payload.data;
    cu = wed_write_data_out.payload.cmd.cu_id_x;
  endtask

  task automatic send_resp(input psl_response_t r, input logic [7:0] cu,
      input logic [7:0] tag);
    wed_response_in = '0;
    wed_response_in.valid = 1'b1;
    wed_response_in.response = r;
    wed_response_in.cmd.cu_id_x = cu;
    wed_response_in.cmd.tag = tag;
    step();
    wed_response_in = '0;
  endtask

  task automatic test_reset();
    logic v;
    logic [511:0] d;
    logic [7:0] cu;
    rstn_in = 1'b0;
    idle_inputs();
    step();
    step();
    total++;
    if (command_out !== '0) begin
      bad++;
      $display("FAIL reset_cmd got=%h want=0", command_out);
    end
    total++;
    if (wed_write_data_out !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", wed_write_data_out.valid);
    end
    total++;
    if ({writeback_done_out, writeback_error_out} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b%b want=00",
               writeback_done_out, writeback_error_out);
    end
    rstn_in = 1'b1;
    step();
    read_half(1'b0, v, d, cu);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL idle_read got=%b want=0", v);
    end
  endtask

  task automatic test_basic();
    int w, dc, c, n0;
    bit ok;
    logic v;
    logic [511:0] d;
    logic [7:0] cu;
    logic [63:0] ecy;
    logic h;
    logic [2:0] hs;
    do_reset();
    pulse_done(64'hDEAD, dc);
    start(64'h1000, w);
    repeat (49) step();
    pulse_done(64'hA5, dc);
    ecy = 64'(dc - w);
    wait_cmd(10, c, ok);
    total++;
    if (!ok || c != dc + 3) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=%0d", c - dc, 3);
    end
    total++;
    if (command_out.address !== 64'h1080 ||
        command_out.command !== WRITE_NA ||
        command_out.size !== 12'h080 ||
        command_out.abt !== STRICT) begin
      bad++;
      $display("FAIL basic_cmd got=%h want=addr 1080 WRITE_NA sz 080",
               command_out);
    end
    total++;
    if (command_out.cmd !== exp_tag()) begin
      bad++;
      $display("FAIL basic_tag got=%h want=%h", command_out.cmd, exp_tag());
    end
    hs = 3'b101;
    for (int i = 0; i < 3; i++) begin
      h = hs[i];
      read_half(h, v, d, cu);
      total++;
      if (v !== 1'b1 || cu !== WED_ID ||
          d !== model_half(64'hA5, ecy, 64'd0, h)) begin
        bad++;
        $display("FAIL basic_read%0d got=%b/%h/%h want=1/%h/%h", i, v, cu,
                 d, WED_ID, model_half(64'hA5, ecy, 64'd0, h));
      end
    end
    send_resp(DONE, WED_ID, 8'd1);
    total++;
    if (writeback_done_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_early got=%b want=0", writeback_done_out);
    end
    step();
    total++;
    if ({writeback_done_out, writeback_error_out} !== 2'b10) begin
      bad++;
      $display("FAIL basic_done got=%b%b want=10",
               writeback_done_out, writeback_error_out);
    end
    n0 = ncmd;
    enabled_in = 1'b0;
    pulse_done(64'h1, dc);
    read_half(1'b0, v, d, cu);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL done_read got=%b want=0", v);
    end
    repeat (10) step();
    total++;
    if (ncmd != n0 || writeback_done_out !== 1'b1) begin
      bad++;
      $display("FAIL done_terminal got=%0d/%b want=%0d/1", ncmd,
               writeback_done_out, n0);
    end
  endtask

  task automatic test_retry();
    int w, dc, c, n0;
    bit ok;
    logic v;
    logic [511:0] d;
    logic [7:0] cu;
    logic [63:0] a, st, ecy;
    do_reset();
    a = {$urandom, $urandom};
    st = {$urandom, $urandom};
    n0 = ncmd;
    start(a, w);
    repeat ($urandom_range(2, 20)) step();
    pulse_done(st, dc);
    ecy = 64'(dc - w);
    for (int k = 0; k < 3; k++) begin
      wait_cmd(20, c, ok);
      total++;
      if (!ok || command_out.address !== a + 64'd128) begin
        bad++;
        $display("FAIL retry_cmd%0d got=%b/%h want=1/%h", k, ok,
                 command_out.address, a + 64'd128);
      end
      if (k == 0) begin
        total++;
        if (c != dc + 3) begin
          bad++;
          $display("FAIL retry_latency got=%0d want=3", c - dc);
        end
      end
      if (k < 2) begin
        read_half(1'b0, v, d, cu);
        send_resp(AERROR, WED_ID, 8'd1);
      end else begin
        wed_response_in = '0;
        wed_response_in.valid = 1'b1;
        wed_response_in.response = DONE;
        wed_response_in.cmd.cu_id_x = WED_ID;
        wed_response_in.cmd.tag = 8'd1;
        read_half(1'b0, v, d, cu);
        wed_response_in = '0;
      end
      total++;
      if (v !== 1'b1 || d !== model_half(st, ecy, 64'(k), 1'b0)) begin
        bad++;
        $display("FAIL retry_word2_%0d got=%b/%h want=1/%h", k, v, d,
                 model_half(st, ecy, 64'(k), 1'b0));
      end
    end
    step();
    step();
    total++;
    if ({writeback_done_out, writeback_error_out} !== 2'b10 ||
        ncmd - n0 != 3) begin
      bad++;
      $display("FAIL retry_end got=%b%b/%0d want=10/3", writeback_done_out,
               writeback_error_out, ncmd - n0);
    end
  endtask

  task automatic test_exhaust();
    int w, dc, c, n0;
    bit ok;
    logic v;
    logic [511:0] d;
    logic [7:0] cu;
    logic [63:0] a, st, ecy;
    psl_response_t nd [4];
    nd = '{AERROR, DERROR, FAILED, PAGED};
    do_reset();
    a = 64'hFFFF_FFFF_FFFF_FFC0;
    st = {$urandom, $urandom};
    n0 = ncmd;
    start(a, w);
    repeat ($urandom_range(1, 8)) step();
    pulse_done(st, dc);
    ecy = 64'(dc - w);
    for (int k = 0; k < 4; k++) begin
      wait_cmd(20, c, ok);
      total++;
      if (!ok || command_out.address !== 64'h40) begin
        bad++;
        $display("FAIL exh_cmd%0d got=%b/%h want=1/40", k, ok,
                 command_out.address);
      end
      read_half(1'b0, v, d, cu);
      total++;
      if (d !== model_half(st, ecy, 64'(k), 1'b0)) begin
        bad++;
        $display("FAIL exh_word2_%0d got=%h want=%h", k, d,
                 model_half(st, ecy, 64'(k), 1'b0));
      end
      send_resp(nd[$urandom_range(0, 3)], WED_ID, 8'd1);
    end
    wait_cmd(20, c, ok);
    total++;
    if (ok) begin
      bad++;
      $display("FAIL exh_extra_cmd got=1 want=0");
    end
    read_half(1'b1, v, d, cu);
    total++;
    if ({writeback_done_out, writeback_error_out} !== 2'b01 ||
        ncmd - n0 != 4 || v !== 1'b0) begin
      bad++;
      $display("FAIL exh_end got=%b%b/%0d/%b want=01/4/0",
               writeback_done_out, writeback_error_out, ncmd - n0, v);
    end
  endtask

  task automatic test_backpressure();
    int w, dc, dc2, c, n0, rel;
    bit ok;
    logic v;
    logic [511:0] d;
    logic [7:0] cu;
    logic [63:0] st, ecy;
    do_reset();
    st = {$urandom, $urandom};
    n0 = ncmd;
    start({$urandom, $urandom}, w);
    repeat ($urandom_range(1, 10)) step();
    command_buffer_status.alfull = 1'b1;
    pulse_done(st, dc);
    step();
    pulse_done(~st, dc2);
    wait_cmd(8, c, ok);
    total++;
    if (ok) begin
      bad++;
      $display("FAIL bp_stall_cmd got=1 want=0");
    end
    command_buffer_status.alfull = 1'b0;
    rel = cyc;
    ecy = 64'(rel - w - 1);
    wait_cmd(10, c, ok);
    total++;
    if (!ok || c != rel + 2) begin
      bad++;
      $display("FAIL bp_release got=%0d want=%0d", c, rel + 2);
    end
    read_half(1'b0, v, d, cu);
    total++;
    if (d !== model_half(st, ecy, 64'd0, 1'b0)) begin
      bad++;
      $display("FAIL bp_snapshot got=%h want=%h", d,
               model_half(st, ecy, 64'd0, 1'b0));
    end
    send_resp(DONE, WED_ID, 8'd0);
    send_resp(DONE, WED_ID ^ 8'h01, 8'd1);
    repeat (3) step();
    total++;
    if (writeback_done_out !== 1'b0 || writeback_error_out !== 1'b0 ||
        ncmd - n0 != 1) begin
      bad++;
      $display("FAIL bp_stray got=%b%b/%0d want=00/1", writeback_done_out,
               writeback_error_out, ncmd - n0);
    end
    send_resp(DONE, WED_ID, 8'd1);
    step();
    total++;
    if (writeback_done_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_done got=%b want=1", writeback_done_out);
    end
  endtask

  task automatic test_midreset();
    int w, dc, c;
    bit ok;
    logic v;
    logic [511:0] d;
    logic [7:0] cu;
    logic [63:0] st;
    do_reset();
    start({$urandom, $urandom}, w);
    repeat (3) step();
    pulse_done({$urandom, $urandom}, dc);
    wait_cmd(10, c, ok);
    total++;
    if (!ok || command_out.valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_cmd got=%b want=1", ok);
    end
    #2;
    rstn_in = 1'b0;
    #1;
    total++;
    if (command_out !== '0 || wed_write_data_out !== '0 ||
        writeback_done_out !== 1'b0 || writeback_error_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got=%b/%b want=0/0", command_out.valid,
               wed_write_data_out.valid);
    end
    step();
    rstn_in = 1'b1;
    step();
    start(64'h2000, w);
    wait_cmd(30, c, ok);
    total++;
    if (ok) begin
      bad++;
      $display("FAIL mid_stale_cmd got=1 want=0");
    end
    st = {$urandom, $urandom};
    pulse_done(st, dc);
    wait_cmd(10, c, ok);
    total++;
    if (!ok || c != dc + 3 || command_out.address !== 64'h2080) begin
      bad++;
      $display("FAIL mid_new_cmd got=%0d/%h want=%0d/2080", c,
               command_out.address, dc + 3);
    end
    read_half(1'b0, v, d, cu);
    total++;
    if (d !== model_half(st, 64'(dc - w), 64'd0, 1'b0)) begin
      bad++;
      $display("FAIL mid_snapshot got=%h want=%h", d,
               model_half(st, 64'(dc - w), 64'd0, 1'b0));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_retry();
    test_exhaust();
    test_backpressure();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wed_writeback_control.md
# wed_writeback_control

Write-side counterpart of the WED fetch path in the AFU. Once the WED is valid and the compute units signal completion, it builds a 128-byte status cacheline (status word, elapsed-cycle count, retry count) and issues a WRITE_NA to the line following the WED. It serves the PSL buffer-read data requests for that line and retries on non-DONE responses. It sits beside the WED fetch control, shares the command buffer arbiter port, and uses the same `WED_ID` routing.

## Interface
Parameters:
- `STATUS_OFFSET`, default 128: byte offset of the status line from the WED address.
- `MAX_RETRIES`, default 3: reissues allowed after a non-DONE response.

Ports:
- `clock`  in  1: single clock.
- `rstn_in`  in  1: reset, asynchronous, active-low.
- `enabled_in`  in  1: AFU enable. Registered once internally.
- `wed_request_in`  in  WEDInterface: `.valid` and `.payload.address`.
- `done_in`  in  1: single-cycle pulse, all CUs finished.
- `done_status_in`  in  64: status word, sampled with `done_in`.
- `command_buffer_status`  in  BufferStatus: `.alfull` gates issue.
- `wed_response_in`  in  ResponseBufferLine: PSL response.
- `buffer_read_valid_in`  in  1: PSL buffer-read request already routed to `WED_ID`.
- `buffer_read_half_in`  in  1: requested half. 0 = bits [0:511], 1 = bits [512:1023].
- `command_out`  out  CommandBufferLine: write command.
- `wed_write_data_out`  out  ReadWriteDataLine: one 512-bit half. `.payload.cmd.cu_id_x = WED_ID`.
- `writeback_done_out`  out  1: status line committed. Sticky.
- `writeback_error_out`  out  1: retries exhausted. Sticky.

## Operation
- **Reset:**
  - Assertion of `rstn_in` asynchronously clears all state and outputs.
  - All valids are 0, counters are 0 and the line register is 0.
  - The state is `WB_RESET`, then `WB_IDLE` on the next cycle.
- **States:**
  - `WB_IDLE` → `WB_WAIT_DONE` when `enabled` and `wed_request_in.valid`. The cycle counter clears.
  - `WB_WAIT_DONE`:
    - The cycle counter increments each cycle and saturates at all-ones.
    - `done_in` sets `done_pending` and captures `done_status_in`.
    - Exit → `WB_REQ` when `done_pending` and not `alfull`.
  - `WB_REQ`:
    - The line snapshot is frozen on entry: word0 = status, word1 = cycles, word2 = retry count (zero-extended), words 3-15 = 0.
    - Words are placed in bit order with no byte swap.
    - Next state is `WB_WAITING_FOR_RESPONSE`.
  - `WB_WAITING_FOR_RESPONSE` exits on a matching response, i.e. `.valid`, `cmd.cu_id_x == WED_ID` and `cmd.tag == 1`:
    - DONE → `WB_DONE`.
    - Otherwise, if retry < `MAX_RETRIES` → `WB_RETRY` and retry increments.
    - Otherwise → `WB_ERROR`.
  - `WB_RETRY` → `WB_REQ` when not `alfull`. The snapshot is not rebuilt; only word2 updates.
  - `WB_DONE` and `WB_ERROR` are terminal until reset. `enabled_in` low does not leave them.
- **`command_out` fields in `WB_REQ`:**
  - `size` = 12'h080, `command` = WRITE_NA.
  - `address` = WED address + `STATUS_OFFSET` (64-bit wrap).
  - `cu_id_x`/`cu_id_y` = `WED_ID`, `cmd_type` = CMD_WED, `array_struct` = STRUCT_INVALID.
  - `real_size` = 32, `real_size_bytes` = 128, offsets 0, `tag` = 1 (distinguishes it from the WED read, which uses tag 0), `abt` = STRICT.
- **Buffer reads:**
  - Honoured in `WB_REQ`, `WB_WAITING_FOR_RESPONSE` and `WB_RETRY`.
  - Each request returns the requested half of the snapshot. Repeats and either order are allowed.
  - Requests in any other state are ignored; the output valid stays 0.
- **Boundary conditions:**
  - `done_in` in `WB_IDLE` is ignored.
  - Extra `done_in` pulses after the first do not recapture.
  - Non-matching responses are ignored.
  - A response and a buffer read in the same cycle are both serviced.

## Timing
- `command_out.valid`:
  - High for exactly one cycle, the cycle after entering `WB_REQ`.
  - Low in all other cycles.
- `wed_write_data_out.valid` is high exactly one cycle after `buffer_read_valid_in`, carrying that request's half.
- `writeback_done_out` and `writeback_error_out` rise on the cycle after the state is entered.
- Minimum latency from the `done_in` cycle to `command_out.valid` is 3 cycles, given not `alfull`.
- `alfull` stalls only the `WB_WAIT_DONE`→`WB_REQ` and `WB_RETRY`→`WB_REQ` transitions.

## Test plan
- **Basic writeback:**
  - Stimulus: WED address 0x1000, valid at t0, `done_in` at t0+50 with status 0xA5, response DONE.
  - Expected: one command to address 0x1080, WRITE_NA, size 0x080. Word0 = 0xA5, word1 ≈ 50, word2 = 0. `writeback_done_out` = 1.
- **Buffer reads:**
  - Stimulus: half 1, then half 0, then half 1 again.
  - Expected: each returned one cycle later with the correct 512 bits and `cu_id_x = WED_ID`.
- **Retry:**
  - Stimulus: responses AERROR, AERROR, then DONE.
  - Expected: three commands with word2 = 0, 1, 2; done set; error clear.
- **Exhaustion:**
  - Stimulus: 4 non-DONE responses.
  - Expected: 4 commands, `writeback_error_out` = 1, no further commands.
- **Backpressure and filtering:**
  - Stimulus: `alfull` held 10 cycles after `done_in`; a response with tag 0 and another with a different `cu_id_x` injected.
  - Expected: no command during the stall; the stray responses are ignored.
- **Mid-operation reset:**
  - Stimulus: `rstn_in` low in `WB_WAITING_FOR_RESPONSE`.
  - Expected: all outputs 0 asynchronously; after release, no command until a new `done_in`.
